muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_ctrl_if.sv | 34 +++
 rtl/muldiv_ctrl.sv | 133 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, state encoding and widths for muldiv_ctrl
package muldiv_pkg;

  localparam int DATA_W   = 32;
  localparam int RESULT_W = 64;

  // op_type encoding as presented by the EX stage
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_type_e;

  // controller state encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL1    = 3'd1,
    ST_MUL2    = 3'd2,
    ST_DIV_RUN = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - controller-to-arithmetic-unit bus (multiplier and divider side)
interface muldiv_ctrl_if;
  import muldiv_pkg::*;

  // 2-cycle multiplier
  logic                mul_signed_o;
  logic [DATA_W-1:0]   mul_ina_o;
  logic [DATA_W-1:0]   mul_inb_o;
  logic [RESULT_W-1:0] mul_result_i;

  // iterative divider; result is {rem, quot}
  logic                div_start_o;
  logic                div_signed_o;
  logic                div_annul_o;
  logic [DATA_W-1:0]   div_opdata1_o;
  logic [DATA_W-1:0]   div_opdata2_o;
  logic                div_ready_i;
  logic [RESULT_W-1:0] div_result_i;

  // controller side
  modport master (
    output mul_signed_o, mul_ina_o, mul_inb_o,
    output div_start_o, div_signed_o, div_annul_o, div_opdata1_o, div_opdata2_o,
    input  mul_result_i, div_ready_i, div_result_i
  );

  // arithmetic-unit side
  modport slave (
    input  mul_signed_o, mul_ina_o, mul_inb_o,
    input  div_start_o, div_signed_o, div_annul_o, div_opdata1_o, div_opdata2_o,
    output mul_result_i, div_ready_i, div_result_i
  );

endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - EX-stage mult/div sequencer with HI/LO write; optional MULDIV_DIVZERO_FASTPATH_EN
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              op_valid,
  input  logic [1:0]        op_type,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              stall_o,
  output logic              hi_we,
  output logic              lo_we,
  output logic [DATA_W-1:0] hi_wdata,
  output logic [DATA_W-1:0] lo_wdata,
  muldiv_ctrl_if.master     unit_bus
);

  state_e              state_q, state_d;
  op_type_e            op_q, op_d;
  logic [DATA_W-1:0]   src1_q, src1_d;
  logic [DATA_W-1:0]   src2_q, src2_d;
  logic [RESULT_W-1:0] result_q, result_d;

  logic in_mul;
  logic in_div;
  logic in_done;

  // state and latched operand/result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULT;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
    end
  end

  // next state: accept in IDLE, sequence the unit, any flush before DONE abandons the op
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (op_valid && !flush) begin
          op_d     = op_type_e'(op_type);
          src1_d   = src1;
          src2_d   = src2;
          result_d = '0;
          if (!op_type[1]) begin
            state_d = ST_MUL1;
          end else begin
            state_d = ST_DIV_RUN;
`ifdef MULDIV_DIVZERO_FASTPATH_EN
            // divide by zero bypasses the divider: hi = dividend, lo = all ones
            if (src2 == '0) begin
              state_d  = ST_DONE;
              result_d = {src1, {DATA_W{1'b1}}};
            end
`endif
          end
        end
      end
      ST_MUL1: begin
        state_d = flush ? ST_IDLE : ST_MUL2;
      end
      ST_MUL2: begin
        state_d = flush ? ST_IDLE : ST_DONE;
      end
      ST_DIV_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (unit_bus.div_ready_i) begin
          result_d = unit_bus.div_result_i;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        // the instruction has committed; a flush here does not cancel the write
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // outputs decoded from the current state; everything but stall is zero in IDLE
  always_comb begin
    in_mul  = (state_q == ST_MUL1) || (state_q == ST_MUL2);
    in_div  = (state_q == ST_DIV_RUN);
    in_done = (state_q == ST_DONE);

    stall_o = resetn && (((state_q == ST_IDLE) && op_valid && !flush) || in_mul || in_div);

    unit_bus.mul_signed_o  = in_mul && (op_q == OP_MULT);
    unit_bus.mul_ina_o     = in_mul ? src1_q : '0;
    unit_bus.mul_inb_o     = in_mul ? src2_q : '0;

    // start drops in the cycle the divider reports ready
    unit_bus.div_start_o   = in_div && !unit_bus.div_ready_i;
    unit_bus.div_signed_o  = in_div && (op_q == OP_DIV);
    unit_bus.div_annul_o   = in_div && flush;
    unit_bus.div_opdata1_o = in_div ? src1_q : '0;
    unit_bus.div_opdata2_o = in_div ? src2_q : '0;

    hi_we    = in_done;
    lo_we    = in_done;
    hi_wdata = '0;
    lo_wdata = '0;
    if (in_done) begin
      if (op_q[1]) begin
        hi_wdata = result_q[RESULT_W-1:DATA_W];
        lo_wdata = result_q[DATA_W-1:0];
      end else begin
        hi_wdata = unit_bus.mul_result_i[RESULT_W-1:DATA_W];
        lo_wdata = unit_bus.mul_result_i[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed bench for muldiv_ctrl with timeline model and unit models
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_type = 2'b00;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        stall_o, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  muldiv_ctrl_if ubus();

  muldiv_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .op_valid (op_valid),
    .op_type  (op_type),
    .src1     (src1),
    .src2     (src2),
    .stall_o  (stall_o),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .unit_bus (ubus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endfunction

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint pa, pb;
    int sa, sb;
    sa = a;
    sb = b;
    if (s) begin
      pa = sa;
      pb = sb;
    end else begin
      pa = {32'b0, a};
      pb = {32'b0, b};
    end
    return 64'(pa * pb);
  endfunction

  function automatic logic [63:0] divres(input logic [31:0] a, input logic [31:0] b, input bit s);
    int sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
      return {32'(r), 32'(q)};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // 2-cycle pipelined multiplier
  logic [63:0] m_s1, m_s2;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_s1 <= '0;
      m_s2 <= '0;
    end else begin
      m_s1 <= prod(ubus.mul_ina_o, ubus.mul_inb_o, ubus.mul_signed_o);
      m_s2 <= m_s1;
    end
  end
  assign ubus.mul_result_i = m_s2;

  // divider: ready LAT cycles after the first start cycle
  int   d_cnt;
  logic d_busy;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_busy <= 1'b0;
      d_cnt  <= 0;
    end else if (ubus.div_annul_o || ubus.div_ready_i) begin
      d_busy <= 1'b0;
      d_cnt  <= 0;
    end else if (ubus.div_start_o) begin
      d_busy <= 1'b1;
      d_cnt  <= d_cnt + 1;
    end
  end
  assign ubus.div_ready_i  = d_busy && (d_cnt == LAT - 1);
  assign ubus.div_result_i = ubus.div_ready_i ?
      divres(ubus.div_opdata1_o, ubus.div_opdata2_o, ubus.div_signed_o) : 64'd0;

  // expected timeline of the current operation
  int          r_k = -100, r_d = -100, r_end = -100, r_annul = -100;
  bit          r_wr = 1'b0, r_fast = 1'b0;
  logic [1:0]  r_t = 2'b00;
  logic [31:0] r_a = '0, r_b = '0, r_hi = '0, r_lo = '0;

  int          stall_cnt = 0, start_cnt = 0, n_wr = 0, last_wr_cyc = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  always @(negedge clk) begin
    int c;
    bit act, mulwin, runwin, we_e, ann_e;
    c      = cyc;
    act    = (c >= r_k) && (c < r_end);
    mulwin = act && !r_t[1] && (c >= r_k + 1) && (c <= r_k + 2);
    runwin = act && r_t[1] && !r_fast && (c >= r_k + 1) && (c <= r_k + LAT);
    we_e   = r_wr && (c == r_d);
    ann_e  = (c == r_annul);
    chk("stall", stall_o, act);
    chk("mul_signed", ubus.mul_signed_o, mulwin && (r_t == 2'b00));
    chk("mul_ina", ubus.mul_ina_o, mulwin ? r_a : 32'd0);
    chk("mul_inb", ubus.mul_inb_o, mulwin ? r_b : 32'd0);
    chk("div_start", ubus.div_start_o, runwin && (c != r_k + LAT));
    chk("div_signed", ubus.div_signed_o, runwin && (r_t == 2'b10));
    chk("div_annul", ubus.div_annul_o, ann_e);
    chk("div_op1", ubus.div_opdata1_o, runwin ? r_a : 32'd0);
    chk("div_op2", ubus.div_opdata2_o, runwin ? r_b : 32'd0);
    chk("hi_we", hi_we, we_e);
    chk("lo_we", lo_we, we_e);
    chk("hi_wdata", hi_wdata, we_e ? r_hi : 32'd0);
    chk("lo_wdata", lo_wdata, we_e ? r_lo : 32'd0);
    if (stall_o) stall_cnt++;
    if (ubus.div_start_o) start_cnt++;
    if (hi_we) begin
      n_wr++;
      last_hi = hi_wdata;
      last_lo = lo_wdata;
      last_wr_cyc = c;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: drop op_valid in DONE; 1: hold op_valid through DONE; 2: hold plus flush in DONE
  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [63:0] e;
    bit fast;
    fast = 1'b0;
`ifdef MULDIV_DIVZERO_FASTPATH_EN
    fast = t[1] && (b == 32'd0);
`endif
    e = t[1] ? divres(a, b, t == 2'b10) : prod(a, b, t == 2'b00);
    r_k = cyc; r_t = t; r_a = a; r_b = b; r_fast = fast;
    r_d = !t[1] ? cyc + 3 : (fast ? cyc + 1 : cyc + LAT + 1);
    r_end = r_d; r_wr = 1'b1; r_annul = -100;
    r_hi = e[63:32]; r_lo = e[31:0];
    op_valid = 1'b1; op_type = t; src1 = a; src2 = b;
    while (cyc < r_d) step();
    if (mode == 0) begin
      op_valid = 1'b0;
    end else begin
      if (mode == 2) flush = 1'b1;
      step();
      op_valid = 1'b0;
      flush = 1'b0;
    end
  endtask

  // flush asserted 'off' cycles after acceptance cycle
  task automatic issue_flush(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b, input int off);
    r_k = cyc; r_t = t; r_a = a; r_b = b; r_fast = 1'b0;
    r_d = cyc + off + 100; r_end = cyc + off + 1; r_wr = 1'b0;
    r_annul = t[1] ? cyc + off : -100;
    op_valid = 1'b1; op_type = t; src1 = a; src2 = b;
    while (cyc < r_k + off) step();
    flush = 1'b1;
    op_valid = 1'b0;
    step();
    flush = 1'b0;
  endtask

  initial begin
    int k0, s0, w0, st0;
    repeat (3) step();
    resetn = 1'b1;
    step();

    // mult -2 * 3 with op_valid held through DONE
    k0 = cyc; s0 = stall_cnt;
    issue(2'b00, 32'hFFFF_FFFE, 32'd3, 1);
    chk("mult_hi", last_hi, 32'hFFFF_FFFF);
    chk("mult_lo", last_lo, 32'hFFFF_FFFA);
    chk("mult_stall_cycles", stall_cnt - s0, 3);
    chk("mult_latency", last_wr_cyc - k0, 3);
    step();

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    chk("multu_hi", last_hi, 32'hFFFF_FFFE);
    chk("multu_lo", last_lo, 32'h0000_0001);

    // divu 100 / 7
    k0 = cyc; s0 = stall_cnt;
    issue(2'b11, 32'd100, 32'd7, 0);
    step();
    chk("divu_hi", last_hi, 32'd2);
    chk("divu_lo", last_lo, 32'd14);
    chk("divu_latency", last_wr_cyc - k0, LAT + 1);
    chk("divu_stall_cycles", stall_cnt - s0, LAT + 1);

    issue(2'b10, 32'hFFFF_FF9C, 32'd7, 0);
    step();
    chk("div_neg_hi", last_hi, 32'hFFFF_FFFE);
    chk("div_neg_lo", last_lo, 32'hFFFF_FFF2);

    // flush with op_valid in IDLE starts nothing
    w0 = n_wr;
    op_valid = 1'b1; op_type = 2'b00; src1 = 32'd5; src2 = 32'd5; flush = 1'b1;
    step();
    op_valid = 1'b0; flush = 1'b0;
    repeat (4) step();
    chk("idle_flush_no_write", n_wr - w0, 0);

    // flush in the 10th cycle of a divide
    w0 = n_wr;
    issue_flush(2'b10, 32'd1000, 32'd3, 10);
    repeat (LAT + 4) step();
    chk("div_flush_no_write", n_wr - w0, 0);

    // flush in MUL1
    w0 = n_wr;
    issue_flush(2'b00, 32'd9, 32'd9, 1);
    repeat (4) step();
    chk("mul_flush_no_write", n_wr - w0, 0);

    // multu then div back to back
    w0 = n_wr;
    issue(2'b01, 32'd12, 32'd10, 0);
    step();
    issue(2'b10, 32'd50, 32'hFFFF_FFF9, 0);
    step();
    chk("b2b_writes", n_wr - w0, 2);
    chk("b2b_hi", last_hi, 32'd1);
    chk("b2b_lo", last_lo, 32'hFFFF_FFF9);

    // flush in DONE still writes
    w0 = n_wr;
    issue(2'b01, 32'd5, 32'd6, 2);
    chk("done_flush_writes", n_wr - w0, 1);
    chk("done_flush_lo", last_lo, 32'd30);

    // reset during MUL2
    r_k = cyc; r_t = 2'b00; r_a = 32'd11; r_b = 32'd13; r_fast = 1'b0;
    r_d = cyc + 3; r_end = cyc + 2; r_wr = 1'b0; r_annul = -100;
    op_valid = 1'b1; op_type = 2'b00; src1 = 32'd11; src2 = 32'd13;
    step();
    step();
    #2;
    resetn = 1'b0;
    op_valid = 1'b0;
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_mul_ina", ubus.mul_ina_o, 0);
    chk("rst_mul_signed", ubus.mul_signed_o, 0);
    chk("rst_hi_we", hi_we, 0);
    chk("rst_div_start", ubus.div_start_o, 0);
    w0 = n_wr;
    step();
    step();
    resetn = 1'b1;
    step();
    chk("rst_no_write", n_wr - w0, 0);
    issue(2'b00, 32'd7, 32'd6, 1);
    chk("restart_lo", last_lo, 32'd42);

    // divide by zero
    st0 = start_cnt;
    issue(2'b11, 32'h1234_5678, 32'd0, 1);
    chk("dz_hi", last_hi, 32'h1234_5678);
    chk("dz_lo", last_lo, 32'hFFFF_FFFF);
`ifdef MULDIV_DIVZERO_FASTPATH_EN
    chk("dz_start_cycles", start_cnt - st0, 0);
`else
    chk("dz_start_cycles", start_cnt - st0, LAT - 1);
`endif
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
